// File: rtl/pipe_pkg.sv
// Shared definitions for the MiniRiscV pipeline registers: default widths,
// control-bundle field offsets and instruction field positions.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W     = 8;

  // Bit offsets of the fields inside the packed control bundle
  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP    = 5;
  localparam int CTRL_ALUOP_W  = 2;

  // Positions of the function fields inside a raw RV32 instruction
  localparam int FUNC3_LSB = 12;
  localparam int FUNC7_LSB = 25;

  // Control bundle as a named structure, MemRead in bit 0
  typedef struct packed {
    logic       spare;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       mem_read;
  } ctrl_t;

  // True when the bundle would change architectural state downstream
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMWRITE] | ctrl[CTRL_REGWRITE];
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_fwd_select.sv
// Priority forwarding mux: matches one register address against all
// writeback sources; the lowest-indexed (youngest) matching source wins.
// Register x0 is never forwarded.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [XLEN-1:0]           fallback,
  output logic                      hit,
  output logic [XLEN-1:0]           data
);

  // Scan oldest to youngest so the youngest match is the last one assigned
  always_comb begin
    hit  = 1'b0;
    data = fallback;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_we[j] && (fwd_rd[j*REG_AW +: REG_AW] == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = fwd_data[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with internal operand forwarding, stall-hold with
// forwarded-operand refresh, flush-to-bubble and a saturating bubble counter.
// All state changes on the falling edge of clk; rst is async active-low.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_OPS = 2,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      in_valid,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [31:0]               in_instr,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic [NUM_OPS*REG_AW-1:0] in_rs_addr,
  input  logic [NUM_OPS*XLEN-1:0]   in_rs_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      out_valid,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [XLEN-1:0]           out_imm,
  output logic [2:0]                out_func3,
  output logic [6:0]                out_func7,
  output logic [REG_AW-1:0]         out_rd,
  output logic [NUM_OPS*REG_AW-1:0] out_rs_addr,
  output logic [NUM_OPS*XLEN-1:0]   out_rs_data,
  output logic [NUM_OPS-1:0]        out_fwd_hit,
  output logic [CNT_W-1:0]          bubble_cnt
);

  import pipe_pkg::*;

  logic [NUM_OPS-1:0]      ld_hit;
  logic [NUM_OPS*XLEN-1:0] ld_data;
  logic [NUM_OPS-1:0]      rf_hit;
  logic [NUM_OPS*XLEN-1:0] rf_data;
  logic                    make_bubble;
  logic                    instr_unused;

  // Only func3/func7 are carried forward; the other instruction bits are
  // already represented by the decoded fields.
  assign instr_unused = ^{in_instr[FUNC7_LSB-1:FUNC3_LSB+3], in_instr[FUNC3_LSB-1:0]};

  // A flush, or an empty ID slot while not stalled, turns EX into a bubble
  assign make_bubble = flush | (~stall & ~in_valid);

  // Two forwarding muxes per operand: one for fresh loads, one for refresh
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_select #(
      .XLEN    (XLEN),
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD)
    ) u_ld_sel (
      .addr     (in_rs_addr[i*REG_AW +: REG_AW]),
      .fwd_we   (fwd_we),
      .fwd_rd   (fwd_rd),
      .fwd_data (fwd_data),
      .fallback (in_rs_data[i*XLEN +: XLEN]),
      .hit      (ld_hit[i]),
      .data     (ld_data[i*XLEN +: XLEN])
    );

    fwd_select #(
      .XLEN    (XLEN),
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD)
    ) u_rf_sel (
      .addr     (out_rs_addr[i*REG_AW +: REG_AW]),
      .fwd_we   (fwd_we),
      .fwd_rd   (fwd_rd),
      .fwd_data (fwd_data),
      .fallback (out_rs_data[i*XLEN +: XLEN]),
      .hit      (rf_hit[i]),
      .data     (rf_data[i*XLEN +: XLEN])
    );
  end

  // Stage register: bubble beats stall-refresh, which beats a normal load
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_imm     <= '0;
      out_func3   <= '0;
      out_func7   <= '0;
      out_rd      <= '0;
      out_rs_addr <= '0;
      out_rs_data <= '0;
      out_fwd_hit <= '0;
      bubble_cnt  <= '0;
    end else if (make_bubble) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_imm     <= '0;
      out_func3   <= '0;
      out_func7   <= '0;
      out_rd      <= '0;
      out_rs_addr <= '0;
      out_rs_data <= '0;
      out_fwd_hit <= '0;
      bubble_cnt  <= (&bubble_cnt) ? bubble_cnt : bubble_cnt + CNT_W'(1);
    end else if (stall) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (out_valid && rf_hit[i]) begin
          out_rs_data[i*XLEN +: XLEN] <= rf_data[i*XLEN +: XLEN];
          out_fwd_hit[i]              <= 1'b1;
        end
      end
    end else begin
      out_valid   <= 1'b1;
      out_ctrl    <= in_ctrl;
      out_imm     <= in_imm;
      out_func3   <= in_instr[FUNC3_LSB +: 3];
      out_func7   <= in_instr[FUNC7_LSB +: 7];
      out_rd      <= in_rd;
      out_rs_addr <= in_rs_addr;
      out_rs_data <= ld_data;
      out_fwd_hit <= ld_hit;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios followed by
// random traffic, all compared against a behavioural stage model.
module tb_id_ex_pipe_reg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int NOPS = 2;
  localparam int NFWD = 2;
  localparam int CW   = 8;
  localparam int CNTW = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic              clk, rst, flush, stall, in_valid;
  logic [CW-1:0]     in_ctrl;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_imm;
  logic [RAW-1:0]    in_rd;
  logic [NOPS*RAW-1:0]  in_rs_addr;
  logic [NOPS*XLEN-1:0] in_rs_data;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*RAW-1:0]  fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;

  logic              out_valid;
  logic [CW-1:0]     out_ctrl;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_func3;
  logic [6:0]        out_func7;
  logic [RAW-1:0]    out_rd;
  logic [NOPS*RAW-1:0]  out_rs_addr;
  logic [NOPS*XLEN-1:0] out_rs_data;
  logic [NOPS-1:0]      out_fwd_hit;
  logic [CNTW-1:0]      bubble_cnt;

  // Unpacked views of the operand and forwarding inputs
  logic [RAW-1:0]  rs_addr_a [NOPS];
  logic [XLEN-1:0] rs_data_a [NOPS];
  logic [RAW-1:0]  fwd_rd_a  [NFWD];
  logic [XLEN-1:0] fwd_data_a[NFWD];

  // Behavioural model of what EX should be holding
  logic            m_valid;
  logic [CW-1:0]   m_ctrl;
  logic [31:0]     m_instr;
  logic [XLEN-1:0] m_imm;
  logic [RAW-1:0]  m_rd;
  logic [RAW-1:0]  m_rs_addr[NOPS];
  logic [XLEN-1:0] m_rs_data[NOPS];
  logic            m_hit    [NOPS];
  int              m_cnt;

  int total = 0;
  int bad   = 0;

  id_ex_pipe_reg #(
    .XLEN(XLEN), .REG_AW(RAW), .NUM_OPS(NOPS), .NUM_FWD(NFWD),
    .CTRL_W(CW), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_ctrl(in_ctrl), .in_instr(in_instr), .in_imm(in_imm), .in_rd(in_rd),
    .in_rs_addr(in_rs_addr), .in_rs_data(in_rs_data),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_imm(out_imm),
    .out_func3(out_func3), .out_func7(out_func7), .out_rd(out_rd),
    .out_rs_addr(out_rs_addr), .out_rs_data(out_rs_data),
    .out_fwd_hit(out_fwd_hit), .bubble_cnt(bubble_cnt)
  );

  // Free-running clock; the design acts on the falling edge
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Youngest writer of a non-zero register supplies the operand
  function automatic void fwdPick(input logic [RAW-1:0] a, input logic [XLEN-1:0] fb,
                                  output logic hit, output logic [XLEN-1:0] val);
    hit = 1'b0;
    val = fb;
    if (a == 0) return;
    for (int j = 0; j < NFWD; j++) begin
      if (fwd_we[j] && fwd_rd_a[j] == a) begin
        hit = 1'b1;
        val = fwd_data_a[j];
        return;
      end
    end
  endfunction

  function automatic void modelReset();
    m_valid = 0; m_ctrl = 0; m_instr = 0; m_imm = 0; m_rd = 0; m_cnt = 0;
    for (int i = 0; i < NOPS; i++) begin
      m_rs_addr[i] = 0; m_rs_data[i] = 0; m_hit[i] = 0;
    end
  endfunction

  function automatic void modelEdge();
    logic h;
    logic [XLEN-1:0] v;
    if (flush || (!stall && !in_valid)) begin
      modelReset();
      m_cnt = m_cnt_next();
    end else if (stall) begin
      if (m_valid) begin
        for (int i = 0; i < NOPS; i++) begin
          fwdPick(m_rs_addr[i], m_rs_data[i], h, v);
          if (h) begin
            m_rs_data[i] = v;
            m_hit[i] = 1'b1;
          end
        end
      end
    end else begin
      m_valid = 1; m_ctrl = in_ctrl; m_instr = in_instr; m_imm = in_imm; m_rd = in_rd;
      for (int i = 0; i < NOPS; i++) begin
        m_rs_addr[i] = rs_addr_a[i];
        fwdPick(rs_addr_a[i], rs_data_a[i], h, v);
        m_rs_data[i] = v;
        m_hit[i] = h;
      end
    end
  endfunction

  int saved_cnt;
  function automatic int m_cnt_next();
    return (saved_cnt < CNT_MAX) ? saved_cnt + 1 : CNT_MAX;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    cmp({tag, ".ctrl"},  64'(out_ctrl),  64'(m_ctrl));
    cmp({tag, ".imm"},   64'(out_imm),   64'(m_imm));
    cmp({tag, ".func3"}, 64'(out_func3), 64'(m_instr[14:12]));
    cmp({tag, ".func7"}, 64'(out_func7), 64'(m_instr[31:25]));
    cmp({tag, ".rd"},    64'(out_rd),    64'(m_rd));
    cmp({tag, ".rsaddr"}, 64'(out_rs_addr), 64'({m_rs_addr[1], m_rs_addr[0]}));
    cmp({tag, ".rsdata"}, 64'(out_rs_data), 64'({m_rs_data[1], m_rs_data[0]}));
    cmp({tag, ".fwdhit"}, 64'(out_fwd_hit), 64'({m_hit[1], m_hit[0]}));
    cmp({tag, ".bubbles"}, 64'(bubble_cnt), 64'(m_cnt));
  endtask

  // Drive packed buses from the unpacked views, clock one falling edge, update model
  task automatic applyStimulus();
    in_rs_addr = {rs_addr_a[1], rs_addr_a[0]};
    in_rs_data = {rs_data_a[1], rs_data_a[0]};
    fwd_rd     = {fwd_rd_a[1], fwd_rd_a[0]};
    fwd_data   = {fwd_data_a[1], fwd_data_a[0]};
    @(negedge clk);
    saved_cnt = m_cnt;
    modelEdge();
    #1;
  endtask

  task automatic setLoad(input logic [CW-1:0] c, input logic [31:0] ins, input logic [XLEN-1:0] imm,
                         input logic [RAW-1:0] rd);
    flush = 0; stall = 0; in_valid = 1;
    in_ctrl = c; in_instr = ins; in_imm = imm; in_rd = rd;
  endtask

  task automatic clearFwd();
    fwd_we = '0;
    for (int j = 0; j < NFWD; j++) begin
      fwd_rd_a[j] = '0; fwd_data_a[j] = '0;
    end
  endtask

  initial begin
    rst = 0; flush = 0; stall = 0; in_valid = 0;
    in_ctrl = 0; in_instr = 0; in_imm = 0; in_rd = 0;
    for (int i = 0; i < NOPS; i++) begin rs_addr_a[i] = 0; rs_data_a[i] = 0; end
    clearFwd();
    in_rs_addr = 0; in_rs_data = 0; fwd_rd = 0; fwd_data = 0;
    modelReset();
    saved_cnt = 0;
    #2;
    checkOutput("reset");
    rst = 1;

    // Valid load, then asynchronous reset between edges
    setLoad(8'h0C, 32'hFE00_5033, 32'h1234, 5'd3);
    rs_addr_a[0] = 5'd1; rs_data_a[0] = 32'h11; rs_addr_a[1] = 5'd2; rs_data_a[1] = 32'h22;
    applyStimulus();
    checkOutput("load1");
    cmp("load1.imm_direct", 64'(out_imm), 64'h1234);
    #2 rst = 0;
    #1;
    modelReset();
    checkOutput("midreset");
    rst = 1;

    // Forwarding priority: both sources match, youngest wins
    setLoad(8'h13, 32'h4000_0033, 32'h5, 5'd4);
    rs_addr_a[0] = 5'd5; rs_data_a[0] = 32'h55; rs_addr_a[1] = 5'd6; rs_data_a[1] = 32'h66;
    fwd_we = 2'b11; fwd_rd_a[0] = 5'd5; fwd_rd_a[1] = 5'd5;
    fwd_data_a[0] = 32'hAAAA; fwd_data_a[1] = 32'hBBBB;
    applyStimulus();
    checkOutput("prio_both");
    cmp("prio_both.op0", 64'(out_rs_data[31:0]), 64'hAAAA);
    cmp("prio_both.hit0", 64'(out_fwd_hit[0]), 64'h1);
    fwd_we = 2'b10;
    applyStimulus();
    checkOutput("prio_old");
    cmp("prio_old.op0", 64'(out_rs_data[31:0]), 64'hBBBB);

    // Register x0 must never be forwarded
    clearFwd();
    rs_addr_a[0] = 5'd9; rs_data_a[0] = 32'h99; rs_addr_a[1] = 5'd0; rs_data_a[1] = 32'h0;
    fwd_we = 2'b01; fwd_rd_a[0] = 5'd0; fwd_data_a[0] = 32'hDEAD;
    applyStimulus();
    checkOutput("x0");
    cmp("x0.op1", 64'(out_rs_data[63:32]), 64'h0);
    cmp("x0.hit1", 64'(out_fwd_hit[1]), 64'h0);

    // Stall refresh of a held operand, then hold with no producer
    clearFwd();
    setLoad(8'h0C, 32'h0000_7033, 32'h77, 5'd8);
    rs_addr_a[0] = 5'd7; rs_data_a[0] = 32'h10; rs_addr_a[1] = 5'd11; rs_data_a[1] = 32'h20;
    applyStimulus();
    checkOutput("pre_stall");
    stall = 1;
    in_ctrl = 8'hFF; in_imm = 32'hCAFE; in_rd = 5'd31; in_instr = 32'hFFFF_FFFF;
    rs_addr_a[0] = 5'd12; rs_data_a[0] = 32'h5555;
    fwd_we = 2'b10; fwd_rd_a[1] = 5'd7; fwd_data_a[1] = 32'h99;
    applyStimulus();
    checkOutput("stall_refresh");
    cmp("stall_refresh.op0", 64'(out_rs_data[31:0]), 64'h99);
    cmp("stall_refresh.imm", 64'(out_imm), 64'h77);
    clearFwd();
    applyStimulus();
    checkOutput("stall_hold");
    cmp("stall_hold.op0", 64'(out_rs_data[31:0]), 64'h99);

    // Flush overrides stall, then an empty-slot bubble
    flush = 1; stall = 1;
    applyStimulus();
    checkOutput("flush_stall");
    cmp("flush_stall.ctrl", 64'(out_ctrl), 64'h0);
    cmp("flush_stall.cnt", 64'(bubble_cnt), 64'h1);
    flush = 0; stall = 0; in_valid = 0;
    applyStimulus();
    checkOutput("empty_bubble");
    cmp("empty_bubble.cnt", 64'(bubble_cnt), 64'h2);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      flush    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_ctrl  = CW'($urandom);
      in_instr = $urandom;
      in_imm   = $urandom;
      in_rd    = RAW'($urandom);
      for (int i = 0; i < NOPS; i++) begin
        rs_addr_a[i] = RAW'($urandom_range(0, 3));
        rs_data_a[i] = $urandom;
      end
      fwd_we = NFWD'($urandom);
      for (int j = 0; j < NFWD; j++) begin
        fwd_rd_a[j]   = RAW'($urandom_range(0, 3));
        fwd_data_a[j] = $urandom;
      end
      applyStimulus();
      checkOutput("rand");
    end

    // Counter saturation after a fresh reset
    #2 rst = 0;
    #1;
    modelReset();
    checkOutput("reset2");
    rst = 1;
    clearFwd();
    stall = 0; in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      flush = 1;
      applyStimulus();
      checkOutput("sat");
    end
    cmp("sat.final", 64'(bubble_cnt), 64'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the MiniRiscV core. It captures the decoded control bundle, immediate, instruction fields and NUM_OPS source operands. Operand forwarding is resolved internally by comparing register addresses against NUM_FWD prioritised writeback sources, rather than relying on externally computed forward flags. It adds stall-hold with forwarded-operand refresh, a valid bit, flush-to-bubble and a saturating bubble counter.

Parameters:
XLEN, 32, datapath width of operands, immediate and forward data
REG_AW, 5, register address width
NUM_OPS, 2, number of source-operand channels (rs1, rs2, ...)
NUM_FWD, 2, number of forwarding sources; index 0 is the youngest stage and has the highest priority
CTRL_W, 8, width of packed control bundle (MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp[1:0], spare)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  core clock; all state updates on the falling edge
rst  in  1  asynchronous, active-low reset
flush  in  1  insert bubble (branch/jump taken)
stall  in  1  hold stage contents (load-use hazard)
in_valid  in  1  ID stage holds a real instruction
in_ctrl  in  CTRL_W  decoded control bundle
in_instr  in  32  raw instruction
in_imm  in  XLEN  sign-extended immediate
in_rd  in  REG_AW  destination register
in_rs_addr  in  NUM_OPS*REG_AW  source register addresses, op0 in LSBs
in_rs_data  in  NUM_OPS*XLEN  register-file read data
fwd_we  in  NUM_FWD  forwarding source will write a register
fwd_rd  in  NUM_FWD*REG_AW  forwarding source destination
fwd_data  in  NUM_FWD*XLEN  forwarding source result
out_valid  out  1  EX holds a real instruction
out_ctrl  out  CTRL_W  registered control bundle
out_imm  out  XLEN  registered immediate
out_func3  out  3  instr[14:12]
out_func7  out  7  instr[31:25]
out_rd  out  REG_AW  registered destination
out_rs_addr  out  NUM_OPS*REG_AW  registered source addresses
out_rs_data  out  NUM_OPS*XLEN  registered, forwarded operands
out_fwd_hit  out  NUM_OPS  per-operand flag: the last capture or refresh used a forwarding source
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, including bubble_cnt. The first update occurs on the first falling edge after rst rises.
- Priority at each falling edge: flush > stall > load.
- Forward select per operand i against address A:
  - Candidates are sources j with fwd_we[j]=1, fwd_rd[j]==A and A!=0.
  - The lowest matching j wins and supplies fwd_data[j].
  - With no candidate, the fallback value is used. x0 is never forwarded.
- flush:
  - out_valid, out_ctrl, out_imm, out_func3, out_func7, out_rd, out_rs_addr, out_rs_data and out_fwd_hit all become 0.
  - bubble_cnt increments. Flush overrides a simultaneous stall.
- stall (no flush):
  - All fields hold.
  - Refresh: for each op with out_valid=1, a forward-select on out_rs_addr[i] replaces out_rs_data[i] when a candidate exists; out_fwd_hit[i] is set on a hit and holds otherwise. This keeps operands current while the producer drains.
  - bubble_cnt holds.
- load (no flush, no stall), in_valid=1:
  - All out_* fields take in_*; func3/func7 are sliced from in_instr; out_valid=1.
  - out_rs_data[i] = forward-select(in_rs_addr[i]) with fallback in_rs_data[i]; out_fwd_hit[i] records whether a hit occurred.
- load, in_valid=0: identical to flush, including the bubble_cnt increment.
- Latency: one falling edge from in_* to out_*. Flush/stall are sampled on the same edge.
- bubble_cnt saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Package pipe_pkg holds:
  - XLEN and REG_AW defaults.
  - CTRL_W and the bit offsets of each control-bundle field (CTRL_MEMREAD=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2, CTRL_REGWRITE=3, CTRL_ALUSRC=4, CTRL_ALUOP=5..6).
  - A typedef for the control bundle.
- Sub-module fwd_select: combinational priority match of one address against the NUM_FWD sources, outputting hit and data. It is instantiated 2*NUM_OPS times: once per operand for the load path (in_rs_addr) and once per operand for the refresh path (out_rs_addr).

Test Plan:
- Reset mid-operation: load a valid instruction (in_imm=0x1234), assert rst=0 between edges -> all outputs 0 immediately, no clock edge required; bubble_cnt=0.
- Forward priority: in_rs_addr op0=5, fwd_we=2'b11, fwd_rd={5,5}, fwd_data={0xBBBB,0xAAAA} (src1,src0) -> out_rs_data op0=0xAAAA, out_fwd_hit[0]=1; with fwd_we=2'b10 -> 0xBBBB.
- x0 guard: in_rs_addr op1=0, in_rs_data op1=0, fwd_we[0]=1, fwd_rd[0]=0, fwd_data[0]=0xDEAD -> out_rs_data op1=0, out_fwd_hit[1]=0.
- Stall refresh: load op0 addr=7 with data 0x10, then stall=1 with fwd_we[1]=1, fwd_rd[1]=7, fwd_data[1]=0x99 -> out_rs_data op0=0x99 and all other fields unchanged; a following stall edge with no match holds 0x99.
- Flush beats stall: stall=1, flush=1 on a valid stage -> out_valid=0, out_ctrl=0 (RegWrite and MemWrite cleared), bubble_cnt 0->1; in_valid=0 load -> bubble_cnt 1->2.
- Counter saturation with CNT_W=4: apply 20 consecutive flushes -> bubble_cnt reaches 15 and stays at 15.
